booth_bist: RTL and testbench



---
 rtl/booth_bist.sv | 162 ++++++++++++++++
 tb/tb_booth_bist.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/booth_bist.sv
// booth_bist: signed 4x4 radix-2 Booth sequential multiplier with optional built-in self-test.
// Self-test logic and vector table are built only when BOOTH_BIST_SELFTEST_EN is defined.
module booth_bist (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       start,
  input  logic       test,
  output logic [7:0] product,
  output logic       busy,
  output logic       pass
);
`ifdef BOOTH_BIST_SELFTEST_EN
  typedef enum logic [1:0] {IDLE, MUL, BIST_RUN, BIST_DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif
  state_t      r_state;
  logic [4:0]  r_m;
  logic [4:0]  r_acc;
  logic [3:0]  r_q;
  logic        r_qm1;
  logic [1:0]  r_cnt;
  logic [7:0]  r_prod;
  logic        r_busy;
  logic [4:0]  w_sum;
  logic [4:0]  w_acc;
  logic [3:0]  w_q;
  logic [7:0]  w_res;
  assign w_sum = (r_q[0] & ~r_qm1) ? r_acc - r_m :
                 (~r_q[0] & r_qm1) ? r_acc + r_m : r_acc;
  // Arithmetic right shift of {A,Q,Q-1}; Q-1 takes the old Q[0]
  assign w_acc = {w_sum[4], w_sum[4:1]};
  assign w_q   = {w_sum[0], r_q[3:1]};
  assign w_res = {w_acc[3:0], w_q};
  assign product = r_prod;
  assign busy    = r_busy;
`ifdef BOOTH_BIST_SELFTEST_EN
  logic [2:0]  r_idx;
  logic        r_err;
  logic        r_pass;
  logic        r_load;
  logic [3:0]  w_ta;
  logic [3:0]  w_tb;
  logic [7:0]  w_ref;
  logic        w_bad;
  always_comb begin
    w_ta = 4'b0000;
    w_tb = 4'b0000;
    case (r_idx)
      3'd0: begin w_ta = 4'b0011; w_tb = 4'b0101; end
      3'd1: begin w_ta = 4'b1000; w_tb = 4'b1000; end
      3'd2: begin w_ta = 4'b0111; w_tb = 4'b1000; end
      3'd3: begin w_ta = 4'b1111; w_tb = 4'b1111; end
      3'd4: begin w_ta = 4'b0000; w_tb = 4'b1011; end
      3'd5: begin w_ta = 4'b0111; w_tb = 4'b0111; end
      3'd6: begin w_ta = 4'b0101; w_tb = 4'b1101; end
      default: begin w_ta = 4'b1110; w_tb = 4'b0010; end
    endcase
  end
  // Low 8 bits of an 8x8 product of sign-extended operands equal the signed product
  assign w_ref = {{4{w_ta[3]}}, w_ta} * {{4{w_tb[3]}}, w_tb};
  assign w_bad = w_res != w_ref;
  assign pass  = r_pass;
`else
  logic w_unused;
  assign w_unused = test;
  assign pass     = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_busy  <= 1'b0;
`ifdef BOOTH_BIST_SELFTEST_EN
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_pass  <= 1'b0;
      r_load  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef BOOTH_BIST_SELFTEST_EN
          if (test) begin
            r_state <= BIST_RUN;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end else
`endif
          if (start) begin
            r_state <= MUL;
            r_m     <= {a[3], a};
            r_acc   <= '0;
            r_q     <= b;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        MUL: begin
          r_acc <= w_acc;
          r_q   <= w_q;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_prod  <= w_res;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
`ifdef BOOTH_BIST_SELFTEST_EN
        BIST_RUN: begin
          if (!test) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_load) begin
            r_m    <= {w_ta[3], w_ta};
            r_acc  <= '0;
            r_q    <= w_tb;
            r_qm1  <= 1'b0;
            r_cnt  <= '0;
            r_load <= 1'b0;
          end else begin
            r_acc <= w_acc;
            r_q   <= w_q;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_prod <= w_res;
              r_err  <= r_err | w_bad;
              r_idx  <= r_idx + 3'd1;
              r_load <= 1'b1;
              if (r_idx == 3'd7) begin
                r_state <= BIST_DONE;
                r_busy  <= 1'b0;
                r_pass  <= ~(r_err | w_bad);
              end
            end
          end
        end
        BIST_DONE: begin
          if (!test) begin
            r_state <= IDLE;
            r_pass  <= 1'b0;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_bist.sv
// tb_booth_bist: directed self-checking bench for booth_bist with an expected-product scoreboard.
module tb_booth_bist;
  logic       clk = 1'b0;
  logic       rst, start, test;
  logic [3:0] a, b;
  logic [7:0] product;
  logic       busy, pass;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  booth_bist dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .test(test),
    .product(product), .busy(busy), .pass(pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
    int ix, iy, p;
    ix = $signed(x);
    iy = $signed(y);
    p = ix * iy;
    return p[7:0];
  endfunction

  task automatic run_mul(input logic [3:0] x, input logic [3:0] y, input logic [7:0] k, input bit poke);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb_q.push_back(model(x, y));
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (busy && n < 20) begin
      if (poke && n == 1) begin a = ~x; b = ~y; start = 1'b1; end
      @(posedge clk); #1 start = 1'b0;
      n++;
    end
    chk("mul_latency", n, 4);
    if (sb_q.size() > 0) chk("mul_product_sb", product, sb_q.pop_front());
    else chk("sb_underflow", 1, 0);
    chk("mul_product_const", product, k);
    @(posedge clk); #1;
    chk("idle_after_mul", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    bit early;
    rst = 1'b1; start = 1'b0; test = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", product, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    rst = 1'b0;

    run_mul(4'b0011, 4'b0101, 8'h0F, 0);
    run_mul(4'b1000, 4'b0111, 8'hC8, 1);
    run_mul(4'b1111, 4'b1111, 8'h01, 0);
    run_mul(4'b1000, 4'b1000, 8'h40, 0);
    run_mul(4'b0000, 4'b1011, 8'h00, 0);
    run_mul(4'b0101, 4'b1101, 8'hF1, 0);

`ifdef BOOTH_BIST_SELFTEST_EN
    @(negedge clk);
    test = 1'b1;
    sb_q.push_back(8'hFC);
    @(posedge clk); #1;
    chk("bist_busy", busy, 1);
    n = 0; early = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy && (product == 8'hFC || pass)) early = 1;
    end
    chk("bist_cycles", n, 40);
    chk("bist_no_early_fc", early, 0);
    if (sb_q.size() > 0) chk("bist_product_sb", product, sb_q.pop_front());
    else chk("sb_underflow", 1, 0);
    chk("bist_pass", pass, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bist_hold_product", product, 8'hFC);
    chk("bist_hold_pass", pass, 1);
    chk("bist_done_busy", busy, 0);
    @(negedge clk);
    test = 1'b0;
    @(posedge clk); #1;
    chk("bist_exit_pass", pass, 0);
    chk("bist_exit_product", product, 8'hFC);

    run_mul(4'b0011, 4'b0101, 8'h0F, 0);
    @(negedge clk);
    test = 1'b1;
    @(posedge clk);
    early = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (product == 8'hFC) early = 1;
    end
    test = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_pass", pass, 0);
    chk("abort_product", product, 8'hC8);
    chk("abort_no_fc", early, 0);
    @(posedge clk); #1;
    chk("abort_stays_idle", busy, 0);
`else
    @(negedge clk);
    test = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("test_ignored_busy", busy, 0);
    chk("test_ignored_pass", pass, 0);
    chk("test_ignored_product", product, 8'hF1);
    run_mul(4'b0111, 4'b0111, 8'h31, 0);
    test = 1'b0;
`endif

    @(negedge clk);
    a = 4'b0011; b = 4'b0101; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_product", product, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_pass", pass, 0);
    rst = 1'b0;
    run_mul(4'b1110, 4'b0010, 8'hFC, 0);
    chk("post_rst_pass", pass, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
